// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one full-adder cell and a carry flop; SERIAL_ADDER_SUB_EN adds a sub input for a-b.
// Latency: start at edge E0, busy for WIDTH cycles, done pulses after E_WIDTH.
// Backpressure: none; start is ignored while busy and accepted again in IDLE or DONE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [WIDTH-1:0] opa, opb, acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction is a + ~b + 1, so only the captured operand and carry change.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign fa_s = opa[0] ^ opb[0] ^ carry;
  assign fa_c = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= b_eff;
      acc   <= '0;
      carry <= cin_eff;
      cnt   <= '0;
    end else if (state == RUN) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      acc   <= {fa_s, acc[WIDTH-1:1]};
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      // The result register only moves on the final bit, so it holds the old result while running.
      if (last) begin
        sum  <= {fa_s, acc[WIDTH-1:1]};
        cout <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, directed corner cases, random ops vs arithmetic model.
// Define SERIAL_ADDER_SUB_EN for both files to also exercise subtraction.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_s = '0;
  logic         prev_c = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as the user sees them.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    int unsigned r;
    if (s) r = int'(x) + int'((~y) & 8'hFF) + 1;
    else   r = int'(x) + int'(y) + int'(c);
    return r[W:0];
  endfunction

  // Called #1 after a rising edge; drives start now, checks the whole operation
  // and returns #1 after E_WIDTH, with the DUT in DONE.
  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                    input logic isub, input logic [W-1:0] es, input logic ec);
    start = 1'b1; a = ia; b = ib; cin = ic;
`ifdef SERIAL_ADDER_SUB_EN
    sub = isub;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int k = 0; k < W; k++) begin
      chk($sformatf("busy_run%0d", k), {63'd0, busy}, 64'd1);
      chk($sformatf("done_run%0d", k), {63'd0, done}, 64'd0);
      chk($sformatf("sum_hold%0d", k), {56'd0, sum}, {56'd0, prev_s});
      chk($sformatf("cout_hold%0d", k), {63'd0, cout}, {63'd0, prev_c});
      // A start pulse with fresh operands while busy must be ignored.
      if (k == 2) begin start = 1'b1; a = 8'hFF; b = W'($urandom); cin = 1'b1; end
      if (k == 3) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("busy_end", {63'd0, busy}, 64'd0);
    chk("done_end", {63'd0, done}, 64'd1);
    chk("sum", {56'd0, sum}, {56'd0, es});
    chk("cout", {63'd0, cout}, {63'd0, ec});
    prev_s = es; prev_c = ec;
  endtask

  task automatic step_idle();
    @(posedge clk); #1;
    chk("done_gone", {63'd0, done}, 64'd0);
    chk("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  vec_t tbl[6];
  logic [W:0] r;
  logic [W-1:0] ra, rb;
  logic rc;

  initial begin
    tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tbl[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tbl[3] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
    tbl[4] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    tbl[5] = '{8'hF0, 8'hF0, 1'b1, 8'hE1, 1'b1};

    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sum", {56'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      op(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, tbl[i].s, tbl[i].co);
      step_idle();
    end

    // Back-to-back: start in the DONE cycle, second done 9 edges later.
    op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);
    op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0);
    step_idle();

    // Reset in the middle of RUN aborts without a done pulse.
    start = 1'b1; a = 8'h55; b = 8'h66; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_busy_pre", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_sum", {56'd0, sum}, 64'd0);
    chk("mid_rst_cout", {63'd0, cout}, 64'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) rst_n = 1'b1;
      chk($sformatf("no_done%0d", k), {63'd0, done}, 64'd0);
    end
    prev_s = '0; prev_c = 1'b0;
    op(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0);
    step_idle();

`ifdef SERIAL_ADDER_SUB_EN
    op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    step_idle();
    op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
    step_idle();
`endif

    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      r = ref_add(ra, rb, rc, n[0]);
      op(ra, rb, rc, n[0], r[W-1:0], r[W]);
`else
      r = ref_add(ra, rb, rc, 1'b0);
      op(ra, rb, rc, 1'b0, r[W-1:0], r[W]);
`endif
      if (n % 3 == 0) step_idle();
    end
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    step_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
